// File: rtl/radiant_readout_sequencer_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : radiant_readout_sequencer_if                                  |
// | Description : Header stream and LAB4 controller handshake bundle for the   |
// |               readout sequencer.                                           |
// | Revision    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface radiant_readout_sequencer_if;
  logic        hdr_valid_o;
  logic        hdr_ready_i;
  logic [63:0] hdr_data_o;
  logic        lab_start_o;
  logic        lab_done_i;

  // Sequencer side: produces the header and the sequence start strobe
  modport master (
    output hdr_valid_o, hdr_data_o, lab_start_o,
    input  hdr_ready_i, lab_done_i
  );

  // Header FIFO / LAB4 controller side
  modport slave (
    input  hdr_valid_o, hdr_data_o, lab_start_o,
    output hdr_ready_i, lab_done_i
  );
endinterface

`default_nettype wire

// File: rtl/radiant_readout_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module      : radiant_readout_sequencer                                     |
// | Description : Responder side of the trigger/readout handshake. Writes a    |
// |               64-bit event header and runs nseq_i+1 LAB4D readout          |
// |               sequences per trigger; services forced (CalRam/pedestal)     |
// |               sequences; tracks event-FIFO occupancy for the governor.     |
// |               Optional macro RADIANT_SEQ_TIMEOUT_EN adds a lab_done_i      |
// |               watchdog of TO_BITS bits.                                    |
// | Revision    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module radiant_readout_sequencer #(
  parameter int MAX_EVENTS = 4,
  parameter int TO_BITS    = 20
) (
  input  wire logic                          sys_clk_i,
  input  wire logic                          rst_i,
  input  wire logic                          run_i,
  input  wire logic [1:0]                    nseq_i,
  input  wire logic                          trig_i,
  input  wire logic [15:0]                   trig_info_i,
  input  wire logic                          force_i,
  input  wire logic                          ev_consumed_i,
  radiant_readout_sequencer_if.master        bus_if,
  output logic                               readout_running_o,
  output logic                               readout_done_o,
  output logic                               readout_full_o,
  output logic                               busy_o,
  output logic [1:0]                         err_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] C_MAX_EV = 4'(MAX_EVENTS);

  state_t      state_q, state_d;
  logic [31:0] ts_q;
  logic [31:0] ts_lat_q;
  logic [15:0] info_q;
  logic [15:0] evnum_q;
  logic [1:0]  nseq_q;
  logic [1:0]  cnt_q;
  logic        forced_q;
  logic        force_pend_q;
  logic [3:0]  outst_q;
  logic        err0_q;
  logic        run_q;

  logic        w_take_trig;
  logic        w_take_force;
  logic        w_seq_inc;
  logic        w_hdr_xfer;
  logic        w_abort;

`ifdef RADIANT_SEQ_TIMEOUT_EN
  logic [TO_BITS-1:0] to_q;
  logic               err1_q;
  localparam logic [TO_BITS-1:0] C_TO_MAX = {TO_BITS{1'b1}};
`else
  // Timeout error bit is constant zero when the watchdog is not built
  localparam logic C_ERR1_TIE = (TO_BITS > 0) ? 1'b0 : 1'b0;
`endif

  assign w_hdr_xfer         = bus_if.hdr_valid_o & bus_if.hdr_ready_i;
  assign bus_if.hdr_data_o  = {ts_lat_q, info_q, evnum_q};
  assign readout_running_o  = run_q;
  assign readout_full_o     = (outst_q >= C_MAX_EV);
  assign busy_o             = (state_q != ST_IDLE);
`ifdef RADIANT_SEQ_TIMEOUT_EN
  assign err_o              = {err1_q, err0_q};
`else
  assign err_o              = {C_ERR1_TIE, err0_q};
`endif

  // Next-state and strobe decode for the readout FSM
  always_comb begin
    state_d            = state_q;
    bus_if.hdr_valid_o = 1'b0;
    bus_if.lab_start_o = 1'b0;
    readout_done_o     = 1'b0;
    w_take_trig        = 1'b0;
    w_take_force       = 1'b0;
    w_seq_inc          = 1'b0;
    w_abort            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A trigger has priority; a coincident force is parked in force_pend
        if (trig_i && run_q) begin
          w_take_trig = 1'b1;
          state_d     = ST_HDR;
        end else if (force_i || force_pend_q) begin
          w_take_force = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_HDR: begin
        bus_if.hdr_valid_o = 1'b1;
        if (bus_if.hdr_ready_i) begin
          // Header is counted once accepted, but no sequence starts with run off
          state_d = run_q ? ST_START : ST_IDLE;
        end
      end
      ST_START: begin
        bus_if.lab_start_o = 1'b1;
        state_d            = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_if.lab_done_i) begin
          if (!forced_q && !run_q) begin
            state_d = ST_IDLE;
          end else if (cnt_q < nseq_q) begin
            w_seq_inc = 1'b1;
            state_d   = ST_START;
          end else begin
            state_d = forced_q ? ST_IDLE : ST_DONE;
          end
        end
`ifdef RADIANT_SEQ_TIMEOUT_EN
        else if (to_q == C_TO_MAX) begin
          // Triggered events still report done so the governor is not blocked
          w_abort = 1'b1;
          state_d = forced_q ? ST_IDLE : ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        readout_done_o = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Free-running timestamp and registered run enable
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q  <= 32'd0;
      run_q <= 1'b0;
    end else begin
      ts_q  <= ts_q + 32'd1;
      run_q <= run_i;
    end
  end

  // Per-event context: header fields, sequence count, forced flag
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_lat_q <= 32'd0;
      info_q   <= 16'd0;
      nseq_q   <= 2'd0;
      cnt_q    <= 2'd0;
      forced_q <= 1'b0;
    end else begin
      if (w_take_trig) begin
        ts_lat_q <= ts_q;
        info_q   <= trig_info_i;
        nseq_q   <= nseq_i;
        cnt_q    <= 2'd0;
        forced_q <= 1'b0;
      end else if (w_take_force) begin
        nseq_q   <= 2'd0;
        cnt_q    <= 2'd0;
        forced_q <= 1'b1;
      end else if (w_seq_inc) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Event number advances on each accepted header
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)           evnum_q <= 16'd0;
    else if (w_hdr_xfer) evnum_q <= evnum_q + 16'd1;
  end

  // Deferred force request: raised when a force cannot be serviced immediately
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i)             force_pend_q <= 1'b0;
    else if (w_take_force) force_pend_q <= 1'b0;
    else if (force_i && ((state_q != ST_IDLE) || w_take_trig))
      force_pend_q <= 1'b1;
  end

  // Outstanding-event counter and underflow error flag
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= 4'd0;
      err0_q  <= 1'b0;
    end else begin
      if (readout_done_o && ev_consumed_i) begin
        outst_q <= outst_q;
      end else if (readout_done_o) begin
        if (outst_q != 4'hF) outst_q <= outst_q + 4'd1;
      end else if (ev_consumed_i) begin
        if (outst_q == 4'd0) err0_q  <= 1'b1;
        else                 outst_q <= outst_q - 4'd1;
      end
    end
  end

`ifdef RADIANT_SEQ_TIMEOUT_EN
  // Watchdog on lab_done_i while waiting; sticky abort flag
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_q   <= '0;
      err1_q <= 1'b0;
    end else begin
      if ((state_q == ST_WAIT) && !bus_if.lab_done_i) to_q <= to_q + 1'b1;
      else                                            to_q <= '0;
      if (w_abort) err1_q <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_radiant_readout_sequencer.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_radiant_readout_sequencer                                  |
// | Description : Directed self-checking bench for radiant_readout_sequencer.   |
// | Revision    : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_radiant_readout_sequencer;

`ifdef RADIANT_SEQ_TIMEOUT_EN
  localparam int TB_TO_BITS = 8;
`else
  localparam int TB_TO_BITS = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [1:0]  nseq = 2'd0;
  logic        trig = 1'b0;
  logic [15:0] info = 16'd0;
  logic        force_r = 1'b0;
  logic        ev = 1'b0;
  logic        running, done, full, busy;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;
  int n_starts = 0;
  int n_dones = 0;
  logic [31:0] m_ts;

  radiant_readout_sequencer_if ifc ();

  radiant_readout_sequencer #(.MAX_EVENTS(4), .TO_BITS(TB_TO_BITS)) dut (
    .sys_clk_i        (clk),
    .rst_i            (rst),
    .run_i            (run),
    .nseq_i           (nseq),
    .trig_i           (trig),
    .trig_info_i      (info),
    .force_i          (force_r),
    .ev_consumed_i    (ev),
    .bus_if           (ifc),
    .readout_running_o(running),
    .readout_done_o   (done),
    .readout_full_o   (full),
    .busy_o           (busy),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  // Reference timestamp: zero in reset, +1 every clock
  always @(posedge clk or posedge rst) begin
    if (rst) m_ts <= 32'd0;
    else     m_ts <= m_ts + 32'd1;
  end

  always @(posedge clk) begin
    if (ifc.lab_start_o) n_starts++;
    if (done)            n_dones++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One event (trigger and/or force), LAB controller answering 2 cycles into WAIT
  task automatic run_event(input bit do_trig, input bit do_force, input logic [15:0] inf,
                           input logic [1:0] ns, output logic [63:0] hdr, output int hdrs,
                           output int starts, output int dones, output bit ok);
    int cd = 0;
    int idle_cnt = 0;
    hdr = 64'd0; hdrs = 0; starts = 0; dones = 0; ok = 1'b0;
    trig = do_trig; force_r = do_force; info = inf; nseq = ns;
    step();
    trig = 1'b0; force_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (ifc.hdr_valid_o && ifc.hdr_ready_i) begin hdr = ifc.hdr_data_o; hdrs++; end
      if (ifc.lab_start_o) begin starts++; cd = 3; end
      if (done) dones++;
      ifc.lab_done_i = (cd == 1);
      if (cd > 0) cd--;
      if (!busy && cd == 0) idle_cnt++; else idle_cnt = 0;
      if (idle_cnt >= 3) begin ok = 1'b1; break; end
      step();
    end
    ifc.lab_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ifc.hdr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_hdr_valid got %b want 0", ifc.hdr_valid_o); end
    checks++; if (ifc.lab_start_o !== 1'b0) begin errors++; $display("FAIL reset_lab_start got %b want 0", ifc.lab_start_o); end
    checks++; if (ifc.hdr_data_o !== 64'd0) begin errors++; $display("FAIL reset_hdr_data got %h want 0", ifc.hdr_data_o); end
    checks++; if ({done, full, running, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {done, full, running, err}); end
    rst = 1'b0; run = 1'b1;
    step(); step();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL running got %b want 1", running); end
  endtask

  task automatic test_triggered();
    logic [31:0] exp_ts;
    int s0 = n_starts;
    exp_ts = m_ts;
    trig = 1'b1; info = 16'h0005; nseq = 2'd2;
    step();
    trig = 1'b0;
    checks++; if (ifc.hdr_valid_o !== 1'b1) begin errors++; $display("FAIL trg_hdr_valid got %b want 1", ifc.hdr_valid_o); end
    checks++; if (ifc.hdr_data_o !== {exp_ts, 16'h0005, 16'h0000}) begin errors++;
      $display("FAIL trg_hdr_data got %h want %h", ifc.hdr_data_o, {exp_ts, 16'h0005, 16'h0000}); end
    step();
    checks++; if (ifc.lab_start_o !== 1'b1 || ifc.hdr_valid_o !== 1'b0) begin errors++;
      $display("FAIL trg_first_start got start=%b valid=%b want 1/0", ifc.lab_start_o, ifc.hdr_valid_o); end
    step();
    checks++; if (ifc.lab_start_o !== 1'b0) begin errors++; $display("FAIL trg_start_width got %b want 0", ifc.lab_start_o); end
    for (int s = 0; s < 3; s++) begin
      step(); step();
      checks++; if (ifc.lab_start_o !== 1'b0 || done !== 1'b0) begin errors++;
        $display("FAIL trg_wait_quiet seq %0d got start=%b done=%b want 0/0", s, ifc.lab_start_o, done); end
      ifc.lab_done_i = 1'b1;
      step();
      ifc.lab_done_i = 1'b0;
      if (s < 2) begin
        checks++; if (ifc.lab_start_o !== 1'b1 || done !== 1'b0) begin errors++;
          $display("FAIL trg_restart seq %0d got start=%b done=%b want 1/0", s, ifc.lab_start_o, done); end
        step();
      end else begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL trg_done got %b want 1", done); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
          $display("FAIL trg_done_end got done=%b busy=%b want 0/0", done, busy); end
      end
    end
    checks++; if (n_starts - s0 !== 3) begin errors++; $display("FAIL trg_start_count got %0d want 3", n_starts - s0); end
  endtask

  task automatic test_full();
    logic [63:0] hdr; int h, st, dn; bit ok;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_initial got %b want 0", full); end
    ev = 1'b1; step(); ev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_event(1'b1, 1'b0, 16'h0100 + 16'(k), 2'd0, hdr, h, st, dn, ok);
      checks++; if (!ok || h != 1 || st != 1 || dn != 1) begin errors++;
        $display("FAIL full_event %0d got ok=%0d hdrs=%0d starts=%0d dones=%0d want 1/1/1/1", k, ok, h, st, dn); end
      checks++; if (hdr[31:0] !== {16'h0100 + 16'(k), 16'd1 + 16'(k)}) begin errors++;
        $display("FAIL full_hdr %0d got %h want %h", k, hdr[31:0], {16'h0100 + 16'(k), 16'd1 + 16'(k)}); end
      checks++; if (full !== (k == 3)) begin errors++; $display("FAIL full_level %0d got %b want %b", k, full, (k == 3)); end
    end
    ev = 1'b1; step(); ev = 1'b0;
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_drop got %b want 0", full); end
    ev = 1'b1; repeat (3) step(); ev = 1'b0;
    checks++; if (err !== 2'b00) begin errors++; $display("FAIL full_err got %b want 00", err); end
  endtask

  task automatic test_trig_force();
    logic [63:0] hdr; int h, st, dn; bit ok;
    run_event(1'b1, 1'b1, 16'h0AAA, 2'd1, hdr, h, st, dn, ok);
    checks++; if (!ok || h != 1 || st != 3 || dn != 1) begin errors++;
      $display("FAIL tf_counts got ok=%0d hdrs=%0d starts=%0d dones=%0d want 1/1/3/1", ok, h, st, dn); end
    checks++; if (hdr[31:0] !== {16'h0AAA, 16'd5}) begin errors++; $display("FAIL tf_hdr got %h want %h", hdr[31:0], {16'h0AAA, 16'd5}); end
    repeat (4) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tf_idle got %b want 0", busy); end
    ev = 1'b1; step(); ev = 1'b0;
    checks++; if (err !== 2'b00 || full !== 1'b0) begin errors++; $display("FAIL tf_drain got err=%b full=%b want 00/0", err, full); end
  endtask

  task automatic test_err();
    ev = 1'b1; step(); ev = 1'b0;
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL err_set got %b want 01", err); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL err_no_wrap got full=%b want 0", full); end
    repeat (10) step();
    checks++; if (err !== 2'b01) begin errors++; $display("FAIL err_sticky got %b want 01", err); end
  endtask

  task automatic test_stall();
    int viol = 0;
    int s0 = n_starts;
    ifc.hdr_ready_i = 1'b0;
    trig = 1'b1; info = 16'h0033; nseq = 2'd0;
    step();
    trig = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ifc.hdr_valid_o !== 1'b1 || ifc.lab_start_o !== 1'b0) viol++;
      step();
    end
    checks++; if (viol != 0 || n_starts != s0) begin errors++;
      $display("FAIL stall_hold got violations=%0d starts=%0d want 0/0", viol, n_starts - s0); end
    ifc.hdr_ready_i = 1'b1;
    step();
    checks++; if (ifc.lab_start_o !== 1'b1) begin errors++; $display("FAIL stall_release got %b want 1", ifc.lab_start_o); end
    step();
    ifc.lab_done_i = 1'b1; step(); ifc.lab_done_i = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
    step();
  endtask

  task automatic test_run_off();
    int d0;
    run = 1'b0; step(); step();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL runoff_running got %b want 0", running); end
    trig = 1'b1; step(); trig = 1'b0;
    checks++; if (busy !== 1'b0 || ifc.hdr_valid_o !== 1'b0) begin errors++;
      $display("FAIL runoff_ignore got busy=%b valid=%b want 0/0", busy, ifc.hdr_valid_o); end
    run = 1'b1; step(); step();
    d0 = n_dones;
    trig = 1'b1; nseq = 2'd3; step(); trig = 1'b0;
    step(); step();
    run = 1'b0; step();
    ifc.lab_done_i = 1'b1; step(); ifc.lab_done_i = 1'b0;
    checks++; if (busy !== 1'b0 || ifc.lab_start_o !== 1'b0 || n_dones != d0) begin errors++;
      $display("FAIL runoff_mid got busy=%b start=%b dones=%0d want 0/0/0", busy, ifc.lab_start_o, n_dones - d0); end
    run = 1'b1; step(); step();
  endtask

  task automatic test_reset_mid();
    trig = 1'b1; nseq = 2'd1; step(); trig = 1'b0;
    step(); step();
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || err !== 2'b00 || ifc.hdr_data_o !== 64'd0) begin errors++;
      $display("FAIL rstmid got busy=%b err=%b hdr=%h want 0/00/0", busy, err, ifc.hdr_data_o); end
    step(); rst = 1'b0; step();
    ifc.lab_done_i = 1'b1; step(); ifc.lab_done_i = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL idle_done_ignored got busy=%b done=%b want 0/0", busy, done); end
    step();
  endtask

`ifdef RADIANT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int waited = 0;
    bit seen = 1'b0;
    trig = 1'b1; nseq = 2'd0; step(); trig = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done) begin seen = 1'b1; break; end
      waited++;
      step();
    end
    checks++; if (!seen || err[1] !== 1'b1) begin errors++;
      $display("FAIL timeout got done_seen=%0d err=%b want 1/1x", seen, err); end
    checks++; if (waited < 255 || waited > 262) begin errors++; $display("FAIL timeout_len got %0d want ~258", waited); end
    step();
  endtask
`endif

  initial begin
    ifc.hdr_ready_i = 1'b1;
    ifc.lab_done_i  = 1'b0;
    test_reset();
    test_triggered();
    test_full();
    test_trig_force();
    test_err();
    test_stall();
    test_run_off();
    test_reset_mid();
`ifdef RADIANT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
